// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the CPU-to-Wishbone memory bus interface.
// Holds the bus widths, state encodings and default timeout.
package mem_bus_if_pkg;

  localparam int unsigned RegBus         = 32;
  localparam int unsigned SelW           = 4;
  localparam int unsigned StallW         = 6;
  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StBusy      = 2'd1,
    StWaitStall = 2'd2
  } state_e;

endpackage

// File: rtl/mem_bus_if.sv
// Bridges one core ram port onto a Wishbone master with a bus timeout.
// Read data is held in rd_buf while the pipeline is still stalled after the ack.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TimeoutDefault,
  parameter int unsigned STALL_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [StallW-1:0] stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [RegBus-1:0] cpu_addr_i,
  input  logic [SelW-1:0]   cpu_sel_i,
  input  logic [RegBus-1:0] cpu_data_i,
  output logic [RegBus-1:0] cpu_data_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic [RegBus-1:0] wb_adr_o,
  output logic [RegBus-1:0] wb_dat_o,
  input  logic [RegBus-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [SelW-1:0]   wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [RegBus-1:0] rd_buf_q, rd_buf_d;
  logic [RegBus-1:0] adr_q, adr_d;
  logic [RegBus-1:0] dat_q, dat_d;
  logic              we_q, we_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              cyc_q, cyc_d;
  logic [RegBus-1:0] cpu_data;
  logic              stall_req;
  logic              err;
  logic              stall_me;

  assign stall_me = stall_i[STALL_BIT];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_buf_d  = rd_buf_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    cyc_d     = cyc_q;
    cpu_data  = '0;
    stall_req = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_ce_i && !flush_i) begin
          stall_req = 1'b1;
          adr_d     = cpu_addr_i;
          dat_d     = cpu_data_i;
          we_d      = cpu_we_i;
          sel_d     = cpu_sel_i;
          cyc_d     = 1'b1;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // Priority: flush over ack over timeout.
        if (flush_i) begin
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          rd_buf_d = '0;
          state_d  = StIdle;
        end else if (wb_ack_i) begin
          cpu_data = wb_dat_i;
          rd_buf_d = we_q ? '0 : wb_dat_i;
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          state_d  = stall_me ? StWaitStall : StIdle;
        end else if (cnt_q == CntLast) begin
          err      = 1'b1;
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          rd_buf_d = '0;
          state_d  = StIdle;
        end else begin
          stall_req = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      StWaitStall: begin
        cpu_data = rd_buf_q;
        if (flush_i) begin
          rd_buf_d = '0;
          state_d  = StIdle;
        end else if (!stall_me) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs read zero while reset is held, even with a request pending.
  assign cpu_data_o  = rst ? cpu_data : '0;
  assign stall_req_o = rst & stall_req;
  assign err_o       = rst & err;

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rd_buf_q <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_buf_q <= rd_buf_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cyc_q    <= cyc_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: read, write, stall hold, timeout, flush and reset.
module tb_mem_bus_if;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stall_req_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_if #(
    .TIMEOUT  (8),
    .STALL_BIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stall_req_o(stall_req_o),
    .err_o      (err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bus_idle(input string tag);
    check({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
    check({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    stall_i    = '0;
    flush_i    = 1'b0;
    cpu_ce_i   = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0040;
    cpu_sel_i  = 4'hF;
    cpu_data_i = 32'h0;
    wb_dat_i   = 32'h0;
    wb_ack_i   = 1'b0;

    // Reset: request held high but everything reads zero.
    #2;
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("rst_data", cpu_data_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    bus_idle("rst");
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    tick();
    check("rst_hold_cyc", {31'd0, wb_cyc_o}, 32'd0);
    cpu_ce_i = 1'b0;
    rst = 1'b1;
    tick();
    bus_idle("post_rst");

    // Read, ack after two BUSY cycles.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF;
    settle();
    check("rd_req_stall", {31'd0, stall_req_o}, 32'd1);
    check("rd_req_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rd_req_data", cpu_data_o, 32'd0);
    tick();
    check("rd_b1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("rd_b1_stb", {31'd0, wb_stb_o}, 32'd1);
    check("rd_b1_adr", wb_adr_o, 32'h100);
    check("rd_b1_sel", {28'd0, wb_sel_o}, 32'hF);
    check("rd_b1_we", {31'd0, wb_we_o}, 32'd0);
    check("rd_b1_stall", {31'd0, stall_req_o}, 32'd1);
    check("rd_b1_data", cpu_data_o, 32'd0);
    tick();
    check("rd_b2_stall", {31'd0, stall_req_o}, 32'd1);
    check("rd_b2_adr", wb_adr_o, 32'h100);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    settle();
    check("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
    check("rd_ack_stall", {31'd0, stall_req_o}, 32'd0);
    check("rd_ack_err", {31'd0, err_o}, 32'd0);
    tick();
    wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
    settle();
    bus_idle("rd_idle");
    check("rd_idle_data", cpu_data_o, 32'd0);
    // Stray ack while idle is ignored.
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
    settle();
    check("stray_ack_data", cpu_data_o, 32'd0);
    tick();
    wb_ack_i = 1'b0;
    settle();
    bus_idle("stray_ack");

    // Write with immediate ack.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h200; cpu_sel_i = 4'h3;
    cpu_data_i = 32'h1234_ABCD;
    settle();
    check("wr_req_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    cpu_data_i = 32'h0; cpu_sel_i = 4'hF;
    wb_ack_i = 1'b1; wb_dat_i = 32'h0;
    settle();
    check("wr_dat", wb_dat_o, 32'h1234_ABCD);
    check("wr_sel", {28'd0, wb_sel_o}, 32'h3);
    check("wr_we", {31'd0, wb_we_o}, 32'd1);
    check("wr_ack_data", cpu_data_o, 32'd0);
    check("wr_ack_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    wb_ack_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    settle();
    bus_idle("wr_idle");
    check("wr_idle_we", {31'd0, wb_we_o}, 32'd0);
    check("wr_idle_sel", {28'd0, wb_sel_o}, 32'd0);
    check("wr_idle_data", cpu_data_o, 32'd0);

    // Read acked while stalled: data held in WAIT_STALL.
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h300;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA; stall_i = 6'b01_0000;
    settle();
    check("sh_ack_data", cpu_data_o, 32'h55AA_55AA);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    check("sh_w1_data", cpu_data_o, 32'h55AA_55AA);
    check("sh_w1_stall", {31'd0, stall_req_o}, 32'd0);
    bus_idle("sh_w1");
    tick();
    check("sh_w2_data", cpu_data_o, 32'h55AA_55AA);
    tick();
    stall_i = 6'b00_0000;
    settle();
    check("sh_w3_data", cpu_data_o, 32'h55AA_55AA);
    tick();
    check("sh_idle_data", cpu_data_o, 32'd0);
    bus_idle("sh_idle");

    // Timeout with no ack: err on the 8th BUSY cycle.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h400;
    tick();
    for (int i = 1; i < 8; i++) begin
      check($sformatf("to_b%0d_err", i), {31'd0, err_o}, 32'd0);
      check($sformatf("to_b%0d_stall", i), {31'd0, stall_req_o}, 32'd1);
      tick();
    end
    check("to_b8_err", {31'd0, err_o}, 32'd1);
    check("to_b8_stall", {31'd0, stall_req_o}, 32'd0);
    check("to_b8_data", cpu_data_o, 32'd0);
    check("to_b8_cyc", {31'd0, wb_cyc_o}, 32'd1);
    tick();
    cpu_ce_i = 1'b0;
    settle();
    check("to_after_err", {31'd0, err_o}, 32'd0);
    bus_idle("to_after");

    // Flush coinciding with ack: ack discarded.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h500;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; flush_i = 1'b1; stall_i = 6'b01_0000;
    settle();
    check("fl_stall", {31'd0, stall_req_o}, 32'd0);
    check("fl_err", {31'd0, err_o}, 32'd0);
    check("fl_data", cpu_data_o, 32'd0);
    tick();
    wb_ack_i = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0;
    settle();
    bus_idle("fl_idle");
    check("fl_idle_data", cpu_data_o, 32'd0);
    check("fl_idle_err", {31'd0, err_o}, 32'd0);
    stall_i = 6'b00_0000;

    // Reset mid-BUSY, then a fresh read.
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h600;
    tick();
    check("mr_busy_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    bus_idle("mr_rst");
    check("mr_rst_stall", {31'd0, stall_req_o}, 32'd0);
    tick();
    cpu_ce_i = 1'b0; rst = 1'b1;
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h700;
    settle();
    check("mr_req_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    check("mr_b1_adr", wb_adr_o, 32'h700);
    check("mr_b1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_CAFE;
    settle();
    check("mr_ack_data", cpu_data_o, 32'h0BAD_CAFE);
    tick();
    wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
    settle();
    bus_idle("mr_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum BUSY cycles to wait for wb_ack_i before aborting (legal range 1..255).
REQ-002 The block SHALL have parameter STALL_BIT, default 4, meaning the index in stall_i of this pipeline stage's stall bit.
REQ-003 The block SHALL have port clk  in  1  single clock, all state on the rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have ports stall_i  in  6  pipeline stall vector, and flush_i  in  1  pipeline flush.
REQ-006 The block SHALL have CPU-side ports cpu_ce_i in 1, cpu_we_i in 1, cpu_addr_i in 32, cpu_sel_i in 4, and cpu_data_i in 32, forming the request from the core's ram port.
REQ-007 The block SHALL have ports cpu_data_o  out  32  read data to core, stall_req_o  out  1  stall request to pipeline control, and err_o  out  1  one-cycle bus-timeout pulse.
REQ-008 The block SHALL have Wishbone master ports wb_adr_o out 32, wb_dat_o out 32, wb_dat_i in 32, wb_we_o out 1, wb_sel_o out 4, wb_stb_o out 1, wb_cyc_o out 1, and wb_ack_i in 1.

Function
REQ-009 The block SHALL implement the states IDLE, BUSY and WAIT_STALL, held in a registered state variable.
REQ-010 In IDLE with cpu_ce_i=1 and flush_i=0, it SHALL assert stall_req_o combinationally in the same cycle, and register wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o from the cpu_* inputs, set wb_cyc_o=wb_stb_o=1, and enter BUSY on the next edge.
REQ-011 In IDLE with cpu_ce_i=0 or flush_i=1, it SHALL keep stall_req_o=0 and wb_cyc_o=wb_stb_o=0.
REQ-012 In BUSY without wb_ack_i, it SHALL hold all wb_* outputs stable, hold stall_req_o=1, and increment the 8-bit timeout counter, which saturates.
REQ-013 In BUSY with wb_ack_i=1 and flush_i=0, it SHALL drive cpu_data_o=wb_dat_i and stall_req_o=0 combinationally in that cycle.
REQ-014 In the same ack cycle, it SHALL register rd_buf=wb_dat_i for reads (0 for writes), clear cyc/stb/we/sel, and go to WAIT_STALL if stall_i[STALL_BIT]=1, else to IDLE.
REQ-015 In WAIT_STALL, it SHALL drive cpu_data_o=rd_buf and stall_req_o=0, and return to IDLE on the first cycle with stall_i[STALL_BIT]=0.
REQ-016 In IDLE, cpu_data_o SHALL be 0.
REQ-017 In BUSY, cpu_data_o SHALL be 0 until ack.
REQ-018 When the counter reaches TIMEOUT-1 in BUSY without ack, it SHALL abort: assert err_o for exactly one cycle, drive stall_req_o=0 and cpu_data_o=0 that cycle, clear cyc/stb, clear rd_buf, and go to IDLE.
REQ-019 flush_i=1 in BUSY or WAIT_STALL SHALL abort: stall_req_o=0 combinationally, cyc/stb cleared and state IDLE at the next edge, rd_buf cleared, and any ack in that cycle discarded.
REQ-020 On simultaneous ack and timeout, ack SHALL win, with no err_o.
REQ-021 On simultaneous ack and flush, flush SHALL win.
REQ-022 The timeout counter SHALL clear on every entry to BUSY.
REQ-023 wb_cyc_o and wb_stb_o SHALL always be equal, with no back-to-back cycle without one IDLE cycle between.
REQ-024 wb_ack_i received outside BUSY SHALL be ignored.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force state=IDLE, counter=0, rd_buf=0, all wb_* outputs=0, and err_o=0.
REQ-026 While rst=0, cpu_data_o and stall_req_o SHALL read 0.
REQ-027 Reset asserted mid-BUSY SHALL drop wb_cyc_o/wb_stb_o immediately, without waiting for ack.
REQ-028 The first request SHALL be accepted no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 The state encodings, the 32-bit width macros (RegBus), the stall-vector width, and the TIMEOUT default SHALL live in the shared define package.
REQ-030 The block SHALL be a single module with no sub-modules.
REQ-031 The block SHALL instantiate twice in the SOPC, one instance for the instruction port and one for the data port, in front of a Wishbone interconnect.

Verification
REQ-032 The bench SHALL cover a read: addr=0x100, sel=0xF, ack after 2 BUSY cycles with wb_dat_i=0xDEADBEEF, stall_i=0 -> stall_req_o high 3 cycles, cpu_data_o=0xDEADBEEF in the ack cycle, IDLE next.
REQ-033 The bench SHALL cover a write: we=1, sel=0x3, data=0x1234ABCD, immediate ack -> wb_dat_o=0x1234ABCD, wb_sel_o=0x3 held until ack, cpu_data_o=0.
REQ-034 The bench SHALL cover stall hold: read ack 0x55AA55AA with stall_i[4]=1 for 3 cycles -> WAIT_STALL, cpu_data_o=0x55AA55AA those 3 cycles, stall_req_o=0, then IDLE.
REQ-035 The bench SHALL cover timeout: TIMEOUT=8, no ack -> err_o single pulse on the 8th BUSY cycle, cyc/stb low next, cpu_data_o=0.
REQ-036 The bench SHALL cover flush with ack: flush_i=1 coinciding with ack -> data discarded, stall_req_o=0, IDLE next, no err_o.
REQ-037 The bench SHALL cover reset mid-cycle: rst=0 during BUSY -> wb_cyc_o=0 before the next edge, and after release a new request completes normally.
